game_ctrl: RTL
==============

# game_ctrl

Top-level game controller that drives the `trex` block's control inputs: `timer`, `speed`, `jump` and `crash`. It has four jobs: generate the frame/second timebase, debounce the player button into single-cycle jump pulses, ramp game speed over time, and sequence the game through idle, running and crashed states. It sits between the board button and the collision detector on one side and `trex` (plus the obstacle/scroll logic) on the other.

## Interface
Parameters:
- `INIT_SPEED`, 6: speed loaded at reset and on restart.
- `MAX_SPEED`, 13: speed saturation value; must be ≤ 15.
- `SPEEDUP_SEC`, 5: number of seconds of running per +1 speed step.
- `DEBOUNCE`, 16: consecutive stable cycles required to accept a new button level; must be ≥ 1.
- `RESTART_SEC`, 1: minimum number of whole seconds spent in CRASHED before a press restarts the game.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn` in 1: raw, asynchronous jump/start button.
- `hit` in 1: collision flag from the collision detector, synchronous to `clk`.
- `timer` out 6: frame index within the current second, 0..FPS-1.
- `speed` out 4: current game speed.
- `jump` out 1: one-cycle pulse to `trex`.
- `crash` out 1: level, high while in CRASHED.
- `restart` out 1: one-cycle pulse; the top level ORs it into the `rst` of `trex` and the obstacle logic.
- `running` out 1: level, high while in RUNNING.

## Operation
- Timebase:
  - A frame counter counts 0..CLK_PER_FRAME-1 and asserts `tick` on its last count.
  - `timer` increments on `tick`, wrapping from FPS-1 to 0. The wrap event is `sec`.
  - The timebase runs in every state and is never cleared by `restart`.
- Button path:
  - `btn` passes through a 2-flop synchronizer.
  - The debounced level changes only after the synchronized value has differed from it for DEBOUNCE consecutive cycles.
  - A rising edge of the debounced level produces `press`, a one-cycle event.
- FSM states: IDLE, RUNNING, CRASHED.
  - IDLE: `speed`=INIT_SPEED. On `press`, go to RUNNING and pulse `jump` in the same cycle as the transition. `hit` is ignored.
  - RUNNING:
    - On `press`, pulse `jump`.
    - On `hit`, go to CRASHED and raise `crash`.
    - A seconds counter increments on `sec`. When it reaches SPEEDUP_SEC, it clears and `speed` increments, saturating at MAX_SPEED.
  - CRASHED:
    - `crash`=1, `jump` is suppressed and `speed` is frozen. A hold counter counts `sec` events up to RESTART_SEC.
    - A `press` before the hold count is reached is discarded.
    - A `press` after the hold count is reached: pulse `restart`, return to IDLE, reload `speed` to INIT_SPEED, clear the seconds and hold counters, and drop `crash`.
- Simultaneous events:
  - `hit` and `press` in the same RUNNING cycle: the crash wins and no `jump` is emitted.
  - `hit` coinciding with a speed step: the crash wins and `speed` keeps its old value.
  - `sec` arriving in the same cycle as entry to CRASHED does not count toward the hold.

## Timing
- Reset values, held while `rst`=1: `timer`=0, `speed`=INIT_SPEED, `jump`=0, `crash`=0, `restart`=0, `running`=0. State is IDLE and all counters are 0.
- All outputs are registered.
- `jump` and `restart` are each exactly one cycle wide.
- Button latency: with `btn` clean-high from clock edge k, `jump` is high during the cycle following edge k+DEBOUNCE+3.
- Glitch rejection: a `btn` glitch shorter than DEBOUNCE cycles after synchronization produces no `press`.
- Holding `btn` high produces only one `press`. The next `press` requires a debounced low followed by a debounced high.
- Crash latency: `hit` sampled high at edge k in RUNNING gives `crash`=1 and `running`=0 after edge k.
- `timer` updates on the edge where the frame counter wraps.
- Reset mid-operation clears everything immediately, including a partially debounced press.

## Structure
- Package `trex_pkg`:
  - Provides `CLK_PER_FRAME` and `FPS`.
  - Add `game_state_t` (IDLE, RUNNING, CRASHED) to it.
- Frame counter width: `$clog2(CLK_PER_FRAME)`.
- Sub-module `btn_debounce`: synchronizer, debounce counter and rising-edge pulse. Ports: `clk`, `rst`, `btn`, `press`.
- The timebase and the FSM live in `game_ctrl`.

## Test plan
Scenarios 1–5 use DEBOUNCE=4 and SPEEDUP_SEC=1.
- Reset, then run for FPS×CLK_PER_FRAME cycles -> `timer` counts 0..FPS-1 and returns to 0; `speed`=6; `crash`=0; `jump` never asserted.
- `btn` high from edge k, held -> one `jump` pulse during the cycle after edge k+7, `running`=1. A 3-cycle `btn` glitch later -> no pulse.
- In RUNNING for 3 seconds -> `speed` goes 6→7→8, each step on a `sec` edge. With MAX_SPEED=7 -> `speed` stays at 7.
- `hit` and a `press` in the same RUNNING cycle -> `crash`=1, no `jump`, `speed` frozen.
- In CRASHED, press before one `sec` -> ignored. Press after one `sec` -> one-cycle `restart`, `crash`=0, `speed`=6, state IDLE.
- Assert `rst` mid-debounce while RUNNING at `speed`=9 -> all outputs take their reset values at once, and no `jump` follows release of `rst`.

Source files
------------

// File: rtl/trex_pkg.sv
// trex_pkg: shared timebase constants and game state encoding
package trex_pkg;
  localparam int CLK_PER_FRAME = 4;
  localparam int FPS = 60;
  typedef enum logic [1:0] {IDLE, RUNNING, CRASHED} game_state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces the button, emitting a one-cycle press on each debounced rising edge
module btn_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic s1_q, s2_q, db_q, dbp_q, press_q, db_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    flip = (s2_q != db_q) && (cnt_q == CW'(DEBOUNCE - 1));
    cnt_d = (s2_q != db_q && !flip) ? cnt_q + 1'b1 : '0;
    db_d = db_q ^ flip;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {s1_q, s2_q, db_q, dbp_q, press_q} <= '0;
      cnt_q <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      db_q <= db_d;
      dbp_q <= db_q;
      press_q <= db_q & ~dbp_q;
    end
  assign press = press_q;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: frame/second timebase, speed ramp and idle/running/crashed sequencing for trex
module game_ctrl
  import trex_pkg::*;
#(
  parameter int INIT_SPEED = 6,
  parameter int MAX_SPEED = 13,
  parameter int SPEEDUP_SEC = 5,
  parameter int DEBOUNCE = 16,
  parameter int RESTART_SEC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       hit,
  output logic [5:0] timer,
  output logic [3:0] speed,
  output logic       jump,
  output logic       crash,
  output logic       restart,
  output logic       running
);
  localparam int FW = $clog2(CLK_PER_FRAME);
  localparam int SW = $clog2(SPEEDUP_SEC + 1);
  localparam int HW = $clog2(RESTART_SEC + 2);
  logic [FW-1:0] fc_q;
  logic [5:0] timer_q;
  game_state_t state_q, state_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0] speed_q, speed_d;
  logic jump_q, jump_d, restart_q, restart_d, press, tick, sec, step;
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .press(press)
  );
  assign tick = fc_q == FW'(CLK_PER_FRAME - 1);
  assign sec = tick && timer_q == 6'(FPS - 1);
  assign step = sec && sec_cnt_q == SW'(SPEEDUP_SEC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fc_q <= '0;
      timer_q <= '0;
    end else begin
      fc_q <= tick ? '0 : fc_q + 1'b1;
      timer_q <= sec ? '0 : tick ? timer_q + 6'd1 : timer_q;
    end
  always_comb begin
    state_d = state_q;
    sec_cnt_d = sec_cnt_q;
    hold_d = hold_q;
    speed_d = speed_q;
    jump_d = 1'b0;
    restart_d = 1'b0;
    case (state_q)
      IDLE: begin
        speed_d = 4'(INIT_SPEED);
        state_d = press ? RUNNING : IDLE;
        jump_d = press;
      end
      RUNNING:
        if (hit) state_d = CRASHED;
        else begin
          jump_d = press;
          sec_cnt_d = step ? '0 : sec ? sec_cnt_q + 1'b1 : sec_cnt_q;
          speed_d = (step && speed_q < 4'(MAX_SPEED)) ? speed_q + 4'd1 : speed_q;
        end
      CRASHED:
        if (press && hold_q == HW'(RESTART_SEC)) begin
          restart_d = 1'b1;
          state_d = IDLE;
          speed_d = 4'(INIT_SPEED);
          sec_cnt_d = '0;
          hold_d = '0;
        end else if (sec && hold_q != HW'(RESTART_SEC)) hold_d = hold_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sec_cnt_q <= '0;
      hold_q <= '0;
      speed_q <= 4'(INIT_SPEED);
      jump_q <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_cnt_q <= sec_cnt_d;
      hold_q <= hold_d;
      speed_q <= speed_d;
      jump_q <= jump_d;
      restart_q <= restart_d;
    end
  assign timer = timer_q;
  assign speed = speed_q;
  assign jump = jump_q;
  assign restart = restart_q;
  assign crash = state_q == CRASHED;
  assign running = state_q == RUNNING;
endmodule
